// File: rtl/pid_seq.sv
// ============================================================================
//  Module   : pid_seq
//  Purpose  : Error-sample sequencer and motion controller that feeds the
//             PID integrator and turns P/I terms into left/right motor commands.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pid_seq #(
    parameter logic [3:0] P_COEFF   = 4'd3,
    parameter logic [9:0] MAX_FRWRD = 10'h300,
    parameter logic [9:0] RAMP_STEP = 10'd16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic               line_present,
    input  logic signed [15:0] err_raw,
    input  logic               err_raw_vld,
    input  logic signed [9:0]  I_term,
    output logic signed [10:0] err_sat,
    output logic               err_vld,
    output logic               moving,
    output logic               line_rise,
    output logic signed [10:0] lft_spd,
    output logic signed [10:0] rht_spd,
    output logic               spd_vld,
    output logic               overrun
);

    localparam logic [1:0] MS_IDLE    = 2'd0;
    localparam logic [1:0] MS_RAMP    = 2'd1;
    localparam logic [1:0] MS_RUN     = 2'd2;
    localparam logic [1:0] MS_DECEL   = 2'd3;

    localparam logic [1:0] PS_SIDLE   = 2'd0;
    localparam logic [1:0] PS_SAT     = 2'd1;
    localparam logic [1:0] PS_WAIT    = 2'd2;
    localparam logic [1:0] PS_COMBINE = 2'd3;

    localparam logic signed [14:0] c_p_coeff = {11'd0, P_COEFF};

    logic              r_line_s1;
    logic              r_line_s2;
    logic              r_line_hist;
    logic              w_line_sync;
    logic              w_run_ok;

    logic [1:0]        r_pstate;
    logic [1:0]        w_pstate_nxt;
    logic              w_accept;
    logic              w_combine;
    logic              w_overrun;

    logic [1:0]        r_mstate;
    logic [1:0]        w_mstate_nxt;
    logic [9:0]        r_frwrd;
    logic [9:0]        w_frwrd_nxt;
    logic [9:0]        w_frwrd_up;
    logic [9:0]        w_frwrd_dn;
    logic              w_idle_entry;

    logic signed [10:0] w_sat_in;
    logic signed [14:0] w_p;
    logic signed [15:0] w_pid;
    logic signed [15:0] w_adj;
    logic signed [15:0] w_lft;
    logic signed [15:0] w_rht;

    function automatic logic signed [10:0] sat11(input logic signed [15:0] v);
        if (v > 16'sd1023)
            sat11 = 11'sd1023;
        else if (v < 16'shFC00)
            sat11 = 11'sh400;
        else
            sat11 = v[10:0];
    endfunction

    // ---------------------------------------------------------------- line sync
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_s1   <= 1'b0;
            r_line_s2   <= 1'b0;
            r_line_hist <= 1'b0;
            line_rise   <= 1'b0;
        end else begin
            r_line_s1   <= line_present;
            r_line_s2   <= r_line_s1;
            r_line_hist <= r_line_s2;
            line_rise   <= r_line_s2 & ~r_line_hist;
        end
    end

    assign w_line_sync = r_line_s2;
    assign w_run_ok    = go & w_line_sync;

    // ---------------------------------------------------------------- sample pipeline FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_pstate <= PS_SIDLE;
        else
            r_pstate <= w_pstate_nxt;
    end

    always_comb begin
        w_pstate_nxt = r_pstate;
        case (r_pstate)
            PS_SIDLE:   if (err_raw_vld && moving) w_pstate_nxt = PS_SAT;
            PS_SAT:     w_pstate_nxt = PS_WAIT;
            PS_WAIT:    w_pstate_nxt = PS_COMBINE;
            PS_COMBINE: w_pstate_nxt = PS_SIDLE;
            default:    w_pstate_nxt = PS_SIDLE;
        endcase
    end

    always_comb begin
        w_accept  = (r_pstate == PS_SIDLE) && err_raw_vld && moving;
        w_combine = (r_pstate == PS_COMBINE);
        w_overrun = (r_pstate != PS_SIDLE) && err_raw_vld;
    end

    // ---------------------------------------------------------------- motion FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mstate <= MS_IDLE;
            r_frwrd  <= 10'd0;
            moving   <= 1'b0;
        end else begin
            r_mstate <= w_mstate_nxt;
            r_frwrd  <= w_frwrd_nxt;
            moving   <= (w_mstate_nxt != MS_IDLE);
        end
    end

    assign w_frwrd_up = (r_frwrd >= MAX_FRWRD - RAMP_STEP) ? MAX_FRWRD : r_frwrd + RAMP_STEP;
    assign w_frwrd_dn = (r_frwrd <= RAMP_STEP) ? 10'd0 : r_frwrd - RAMP_STEP;

    // Only IDLE->RAMP is free-running; every other move waits for a COMBINE step.
    always_comb begin
        w_mstate_nxt = r_mstate;
        w_frwrd_nxt  = r_frwrd;
        case (r_mstate)
            MS_IDLE: begin
                w_frwrd_nxt = 10'd0;
                if (w_run_ok) w_mstate_nxt = MS_RAMP;
            end
            MS_RAMP: begin
                if (w_combine) begin
                    if (!w_run_ok) begin
                        w_mstate_nxt = MS_DECEL;
                    end else begin
                        w_frwrd_nxt = w_frwrd_up;
                        if (w_frwrd_up == MAX_FRWRD) w_mstate_nxt = MS_RUN;
                    end
                end
            end
            MS_RUN: begin
                if (w_combine && !w_run_ok) w_mstate_nxt = MS_DECEL;
            end
            MS_DECEL: begin
                if (w_combine) begin
                    if (w_run_ok) begin
                        w_mstate_nxt = MS_RAMP;
                    end else begin
                        w_frwrd_nxt = w_frwrd_dn;
                        if (w_frwrd_dn == 10'd0) w_mstate_nxt = MS_IDLE;
                    end
                end
            end
            default: begin
                w_mstate_nxt = MS_IDLE;
                w_frwrd_nxt  = 10'd0;
            end
        endcase
    end

    always_comb begin
        w_idle_entry = w_combine && (r_mstate != MS_IDLE) && (w_mstate_nxt == MS_IDLE);
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        if (err_raw > 16'sd1023)
            w_sat_in = 11'sd1023;
        else if (err_raw < 16'shFC00)
            w_sat_in = 11'sh400;
        else
            w_sat_in = err_raw[10:0];
    end

    assign w_p   = $signed({{4{err_sat[10]}}, err_sat}) * c_p_coeff;
    assign w_pid = $signed({w_p[14], w_p}) + $signed({{6{I_term[9]}}, I_term});
    assign w_adj = w_pid >>> 3;
    // COMBINE sees the pre-update forward speed.
    assign w_lft = $signed({6'd0, r_frwrd}) + w_adj;
    assign w_rht = $signed({6'd0, r_frwrd}) - w_adj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sat <= 11'sd0;
            err_vld <= 1'b0;
            lft_spd <= 11'sd0;
            rht_spd <= 11'sd0;
            spd_vld <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (w_accept) err_sat <= w_sat_in;
            err_vld <= w_accept;
            spd_vld <= w_combine;
            overrun <= w_overrun;
            if (w_combine) begin
                if (w_idle_entry) begin
                    lft_spd <= 11'sd0;
                    rht_spd <= 11'sd0;
                end else begin
                    lft_spd <= sat11(w_lft);
                    rht_spd <= sat11(w_rht);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pid_seq.sv
// ============================================================================
//  Module   : tb_pid_seq
//  Purpose  : Directed self-checking bench for pid_seq.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pid_seq;

    logic        clk;
    logic        rst_n;
    logic        go;
    logic        line_present;
    logic [15:0] err_raw;
    logic        err_raw_vld;
    logic [9:0]  I_term;
    logic [10:0] err_sat;
    logic        err_vld;
    logic        moving;
    logic        line_rise;
    logic [10:0] lft_spd;
    logic [10:0] rht_spd;
    logic        spd_vld;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    pid_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .go          (go),
        .line_present(line_present),
        .err_raw     (err_raw),
        .err_raw_vld (err_raw_vld),
        .I_term      (I_term),
        .err_sat     (err_sat),
        .err_vld     (err_vld),
        .moving      (moving),
        .line_rise   (line_rise),
        .lft_spd     (lft_spd),
        .rht_spd     (rht_spd),
        .spd_vld     (spd_vld),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sample through the pipeline; returns at N+3 after checking commands.
    task automatic sample(input int e, input int it, input logic [10:0] e_sat,
                          input logic [10:0] e_lft, input logic [10:0] e_rht);
        err_raw     = 16'(e);
        I_term      = 10'(it);
        err_raw_vld = 1'b1;
        tick();
        err_raw_vld = 1'b0;
        chk("err_vld", {10'd0, err_vld}, 11'd1);
        chk("err_sat", err_sat, e_sat);
        tick();
        tick();
        chk("spd_vld_early", {10'd0, spd_vld}, 11'd0);
        tick();
        chk("spd_vld", {10'd0, spd_vld}, 11'd1);
        chk("lft_spd", lft_spd, e_lft);
        chk("rht_spd", rht_spd, e_rht);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int ev;
        int sv;
        int ov;
        int rises;
        int rise_at;
        int exp_f;

        rst_n = 1'b0; go = 1'b0; line_present = 1'b0;
        err_raw = 16'd0; err_raw_vld = 1'b0; I_term = 10'd0;
        tick(); tick(); tick();
        chk("rst_err_sat", err_sat, 11'd0);
        chk("rst_err_vld", {10'd0, err_vld}, 11'd0);
        chk("rst_moving",  {10'd0, moving}, 11'd0);
        chk("rst_line_rise", {10'd0, line_rise}, 11'd0);
        chk("rst_lft", lft_spd, 11'd0);
        chk("rst_rht", rht_spd, 11'd0);
        chk("rst_spd_vld", {10'd0, spd_vld}, 11'd0);
        chk("rst_overrun", {10'd0, overrun}, 11'd0);

        rst_n = 1'b1; go = 1'b1; line_present = 1'b1;
        for (w = 0; w < 4 && !moving; w++) tick();
        chk("moving_start", {10'd0, moving}, 11'd1);

        // Ramp: outputs show the forward speed before each increment.
        for (int k = 0; k < 48; k++) sample(0, 0, 11'd0, 11'(16 * k), 11'(16 * k));
        sample(0, 0, 11'd0, 11'h300, 11'h300);
        sample(0, 0, 11'd0, 11'h300, 11'h300);

        // RUN arithmetic and saturation
        sample(5000, 0, 11'h3FF, 11'h3FF, 11'd385);
        sample(-40, -8, 11'h7D8, 11'h2F0, 11'h310);
        sample(-3000, 0, 11'h400, 11'h180, 11'h3FF);
        sample(1024, 100, 11'h3FF, 11'h3FF, 11'h174);

        // Back-to-back strobes: second one is dropped
        err_raw = 16'd100; I_term = 10'd0; err_raw_vld = 1'b1;
        tick();
        ev = err_vld ? 1 : 0;
        sv = spd_vld ? 1 : 0;
        err_raw = 16'd200;
        tick();
        err_raw_vld = 1'b0;
        chk("overrun_pulse", {10'd0, overrun}, 11'd1);
        for (int i = 0; i < 6; i++) begin
            ev += err_vld ? 1 : 0;
            sv += spd_vld ? 1 : 0;
            tick();
        end
        chk("b2b_err_vld_cnt", 11'(ev), 11'd1);
        chk("b2b_spd_vld_cnt", 11'(sv), 11'd1);
        chk("b2b_err_sat", err_sat, 11'd100);
        chk("b2b_lft", lft_spd, 11'h325);
        chk("b2b_rht", rht_spd, 11'h2DB);

        // Deceleration, resume, then full stop
        go = 1'b0;
        sample(0, 0, 11'd0, 11'h300, 11'h300);
        exp_f = 768;
        for (int i = 0; i < 3; i++) begin
            sample(0, 0, 11'd0, 11'(exp_f), 11'(exp_f));
            exp_f -= 16;
        end
        go = 1'b1;
        sample(0, 0, 11'd0, 11'(exp_f), 11'(exp_f));
        sample(0, 0, 11'd0, 11'(exp_f), 11'(exp_f));
        exp_f += 16;
        go = 1'b0;
        sample(0, 0, 11'd0, 11'(exp_f), 11'(exp_f));
        while (exp_f > 16) begin
            sample(0, 0, 11'd0, 11'(exp_f), 11'(exp_f));
            exp_f -= 16;
        end
        sample(0, 0, 11'd0, 11'd0, 11'd0);
        chk("moving_idle", {10'd0, moving}, 11'd0);

        // Samples in IDLE are ignored silently
        err_raw = 16'd50; err_raw_vld = 1'b1;
        tick();
        err_raw_vld = 1'b0;
        ov = 0;
        for (int i = 0; i < 4; i++) begin
            ov += (err_vld ? 1 : 0) + (spd_vld ? 1 : 0) + (overrun ? 1 : 0);
            tick();
        end
        chk("idle_ignore", 11'(ov), 11'd0);

        // line_rise: single pulse, three edges after the rise
        line_present = 1'b0;
        tick(); tick(); tick(); tick();
        chk("line_rise_low", {10'd0, line_rise}, 11'd0);
        line_present = 1'b1;
        rises = 0;
        rise_at = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (line_rise) begin
                rises++;
                rise_at = i;
            end
        end
        chk("line_rise_cnt", 11'(rises), 11'd1);
        chk("line_rise_at", 11'(rise_at), 11'd3);

        // Reset in the middle of a sample
        go = 1'b1;
        for (w = 0; w < 4 && !moving; w++) tick();
        chk("moving_again", {10'd0, moving}, 11'd1);
        sample(5000, 0, 11'h3FF, 11'd383, 11'h681);
        err_raw = 16'd5000; err_raw_vld = 1'b1;
        tick();
        err_raw_vld = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_err_sat", err_sat, 11'd0);
        chk("arst_lft", lft_spd, 11'd0);
        chk("arst_rht", rht_spd, 11'd0);
        chk("arst_moving", {10'd0, moving}, 11'd0);
        chk("arst_err_vld", {10'd0, err_vld}, 11'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ev = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            ev += (err_vld ? 1 : 0) + (spd_vld ? 1 : 0);
        end
        chk("no_stray_strobes", 11'(ev), 11'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
